// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops words from a fifo read port for one transaction of
// TXN_LEN words and packs them into C_RATIO-word output beats. Lane 0 holds
// the first word of a beat. The final beat of a transaction may be partial;
// its unused lanes read as zero and OUT_WORDS gives the number of valid lanes.
module fifo_rd_packer #(
  parameter int C_IN_WIDTH  = 32,
  parameter int C_RATIO     = 4,
  parameter int C_LEN_WIDTH = 32
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [C_LEN_WIDTH-1:0]            TXN_LEN,
  input  logic                              TXN_VALID,
  output logic                              TXN_READY,
  input  logic [C_IN_WIDTH-1:0]             FIFO_DATA,
  input  logic                              FIFO_VALID,
  output logic                              FIFO_READY,
  output logic [C_IN_WIDTH*C_RATIO-1:0]     OUT_DATA,
  output logic [$clog2(C_RATIO+1)-1:0]      OUT_WORDS,
  output logic                              OUT_LAST,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic                              DONE
);

  localparam int LANE_W  = $clog2(C_RATIO);
  localparam int WORDS_W = $clog2(C_RATIO+1);
  localparam int BEAT_W  = C_IN_WIDTH * C_RATIO;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(C_RATIO - 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

  state_t                                  state;
  logic [C_LEN_WIDTH-1:0]                  remaining;
  logic [LANE_W-1:0]                       lane;
  logic [C_RATIO-1:0][C_IN_WIDTH-1:0]      staging;
  logic                                    pop;
  logic                                    close_beat;
  logic                                    last_word;

  // Assemble a beat: staged lanes below the current one, the word being
  // popped in the current lane, and zeros above it. Masking here means the
  // staging lanes never need clearing between beats.
  function automatic logic [BEAT_W-1:0] pack_beat(
    input logic [C_RATIO-1:0][C_IN_WIDTH-1:0] stg,
    input logic [LANE_W-1:0]                  top,
    input logic [C_IN_WIDTH-1:0]              word
  );
    logic [BEAT_W-1:0] beat;
    beat = '0;
    for (int k = 0; k < C_RATIO; k++) begin
      if (LANE_W'(k) < top)
        beat[k*C_IN_WIDTH +: C_IN_WIDTH] = stg[k];
      else if (LANE_W'(k) == top)
        beat[k*C_IN_WIDTH +: C_IN_WIDTH] = word;
    end
    return beat;
  endfunction

  // A word that would close a beat is only popped when the output register
  // is empty or being emptied this cycle; filler words pop freely.
  always_comb begin
    TXN_READY  = (state == IDLE);
    last_word  = (remaining == C_LEN_WIDTH'(1));
    FIFO_READY = (state == PACK) &&
                 (((lane < LAST_LANE) && (remaining > C_LEN_WIDTH'(1))) ||
                  !OUT_VALID || OUT_READY);
    pop        = FIFO_VALID && FIFO_READY;
    close_beat = pop && ((lane == LAST_LANE) || last_word);
  end

  // Transaction FSM with registered beat outputs and DONE pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      lane      <= '0;
      staging   <= '0;
      OUT_DATA  <= '0;
      OUT_WORDS <= '0;
      OUT_LAST  <= 1'b0;
      OUT_VALID <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      // An accepted beat is retired unless a new one loads below.
      if (OUT_VALID && OUT_READY)
        OUT_VALID <= 1'b0;

      case (state)
        IDLE: begin
          if (TXN_VALID) begin
            remaining <= TXN_LEN;
            lane      <= '0;
            if (TXN_LEN == '0)
              DONE  <= 1'b1;
            else
              state <= PACK;
          end
        end

        PACK: begin
          if (pop) begin
            staging[lane] <= FIFO_DATA;
            remaining     <= remaining - C_LEN_WIDTH'(1);
            if (close_beat) begin
              OUT_DATA  <= pack_beat(staging, lane, FIFO_DATA);
              OUT_WORDS <= WORDS_W'(lane) + WORDS_W'(1);
              OUT_LAST  <= last_word;
              OUT_VALID <= 1'b1;
              lane      <= '0;
              if (last_word)
                state <= DRAIN;
            end else begin
              lane <= lane + LANE_W'(1);
            end
          end
        end

        DRAIN: begin
          if (OUT_VALID && OUT_READY) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed testbench for fifo_rd_packer: a fifo source queue feeds words,
// expected beats are queued when each transaction starts and compared as the
// DUT hands them over.
module tb_fifo_rd_packer;

  localparam int IW = 32;
  localparam int R  = 4;
  localparam int LW = 32;
  localparam int DW = IW * R;

  typedef struct {
    logic [DW-1:0] data;
    logic [2:0]    words;
    logic          last;
  } beat_t;

  logic          CLK;
  logic          RST;
  logic [LW-1:0] TXN_LEN;
  logic          TXN_VALID;
  logic          TXN_READY;
  logic [IW-1:0] FIFO_DATA;
  logic          FIFO_VALID;
  logic          FIFO_READY;
  logic [DW-1:0] OUT_DATA;
  logic [2:0]    OUT_WORDS;
  logic          OUT_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          DONE;

  fifo_rd_packer #(.C_IN_WIDTH(IW), .C_RATIO(R), .C_LEN_WIDTH(LW)) dut (
    .CLK(CLK), .RST(RST),
    .TXN_LEN(TXN_LEN), .TXN_VALID(TXN_VALID), .TXN_READY(TXN_READY),
    .FIFO_DATA(FIFO_DATA), .FIFO_VALID(FIFO_VALID), .FIFO_READY(FIFO_READY),
    .OUT_DATA(OUT_DATA), .OUT_WORDS(OUT_WORDS), .OUT_LAST(OUT_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  logic [IW-1:0] src_q[$];
  beat_t         exp_q[$];

  // stimulus controls
  bit  fv_en = 0, fv_toggle = 0, ordy = 1, txn_req = 0;
  int  txn_len_v = 0;

  // per-transaction observations
  int  cyc = 0, txn_cyc = 0, done_cyc = 0, last_acc_cyc = 0;
  int  cur_len = 0, pops = 0, dones = 0, first_pop = 0, last_pop = 0;
  bit  ov_seen = 0, fr_seen = 0, fr_s = 0;
  bit  hold_prev = 0;
  logic [DW-1:0] prev_data;
  logic [2:0]    prev_words;
  logic          prev_last;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // One clock: drive inputs at negedge, sample and score, then wait posedge.
  task automatic cycle();
    beat_t e;
    @(negedge CLK);
    TXN_VALID  = txn_req;
    TXN_LEN    = LW'(txn_len_v);
    FIFO_VALID = fv_en && (!fv_toggle || cyc[0]) && (src_q.size() > 0);
    FIFO_DATA  = (src_q.size() > 0) ? src_q[0] : '0;
    OUT_READY  = ordy;
    #1;
    if (hold_prev) begin
      check("hold_valid", 128'(OUT_VALID), 128'(1));
      check("hold_data",  128'(OUT_DATA),  128'(prev_data));
      check("hold_words", 128'(OUT_WORDS), 128'(prev_words));
      check("hold_last",  128'(OUT_LAST),  128'(prev_last));
    end
    if (TXN_READY)
      check("fifo_ready_idle", 128'(FIFO_READY), 128'(0));
    if (TXN_VALID && TXN_READY) begin
      txn_cyc = cyc;
      txn_req = 0;
    end
    if (OUT_VALID) ov_seen = 1;
    if (FIFO_READY) fr_seen = 1;
    fr_s = FIFO_READY;
    if (OUT_VALID && OUT_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("beat_data",  128'(OUT_DATA),  128'(e.data));
        check("beat_words", 128'(OUT_WORDS), 128'(e.words));
        check("beat_last",  128'(OUT_LAST),  128'(e.last));
      end
      last_acc_cyc = cyc;
    end
    if (FIFO_VALID && FIFO_READY) begin
      check("no_overpop", 128'(pops < cur_len), 128'(1));
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
      void'(src_q.pop_front());
    end
    if (DONE) begin
      dones++;
      done_cyc = cyc;
    end
    hold_prev  = OUT_VALID && !OUT_READY;
    prev_data  = OUT_DATA;
    prev_words = OUT_WORDS;
    prev_last  = OUT_LAST;
    @(posedge CLK);
    cyc++;
  endtask

  // Queue the fifo words and expected beats, then request the transaction.
  task automatic start(input int len, input logic [IW-1:0] base);
    beat_t e;
    int n;
    for (int i = 0; i < len; i++) src_q.push_back(base + IW'(i));
    for (int b = 0; b < len; b += R) begin
      n = (len - b < R) ? (len - b) : R;
      e.data = '0;
      for (int k = 0; k < n; k++) e.data[k*IW +: IW] = base + IW'(b + k);
      e.words = 3'(n);
      e.last  = (b + n == len);
      exp_q.push_back(e);
    end
    cur_len = len; txn_len_v = len;
    pops = 0; dones = 0; ov_seen = 0; fr_seen = 0;
    txn_req = 1;
  endtask

  // Run to DONE (bounded), one more cycle to confirm a single pulse, then score.
  task automatic finish(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      cycle();
      n++;
    end
    if (dones == 0) check("done_timeout", 128'(0), 128'(1));
    cycle();
    check("done_pulses", 128'(dones), 128'(1));
    check("pop_count",   128'(pops),  128'(cur_len));
    check("beats_left",  128'(exp_q.size()), 128'(0));
    if (cur_len == 0)
      check("done_latency0", 128'(done_cyc), 128'(txn_cyc + 1));
    else
      check("done_latency",  128'(done_cyc), 128'(last_acc_cyc + 1));
  endtask

  initial begin
    int n;
    RST = 1'b1; TXN_LEN = '0; TXN_VALID = 1'b0;
    FIFO_DATA = '0; FIFO_VALID = 1'b0; OUT_READY = 1'b0;
    #1;
    check("rst_out_valid",  128'(OUT_VALID),  128'(0));
    check("rst_out_data",   128'(OUT_DATA),   128'(0));
    check("rst_out_words",  128'(OUT_WORDS),  128'(0));
    check("rst_out_last",   128'(OUT_LAST),   128'(0));
    check("rst_done",       128'(DONE),       128'(0));
    check("rst_fifo_ready", 128'(FIFO_READY), 128'(0));
    check("rst_txn_ready",  128'(TXN_READY),  128'(1));
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1: two full beats, full rate
    fv_en = 1; ordy = 1;
    start(8, 32'h0);
    finish(100);
    check("t1_pop_span", 128'(last_pop - first_pop), 128'(7));

    // 2: partial final beat
    start(6, 32'h0);
    finish(100);

    // 3: empty transaction
    start(0, 32'h0);
    finish(20);
    check("t3_no_out_valid",  128'(ov_seen), 128'(0));
    check("t3_no_fifo_ready", 128'(fr_seen), 128'(0));

    // 4: output backpressure after first beat
    start(12, 32'h100);
    ordy = 0;
    n = 0;
    while (!ov_seen && n < 50) begin
      cycle();
      n++;
    end
    if (!ov_seen) check("t4_first_beat_timeout", 128'(0), 128'(1));
    repeat (5) cycle();
    check("t4_pops_stalled", 128'(pops), 128'(7));
    check("t4_fifo_ready_low", 128'(fr_s), 128'(0));
    ordy = 1;
    finish(100);

    // 5: fifo valid every other cycle
    fv_toggle = 1;
    start(5, 32'h0);
    finish(100);
    fv_toggle = 0;

    // 6: reset after two pops, then a clean transaction
    start(8, 32'h200);
    n = 0;
    while (pops < 2 && n < 50) begin
      cycle();
      n++;
    end
    check("t6_two_pops", 128'(pops), 128'(2));
    #2;
    RST = 1'b1;
    #1;
    check("t6_rst_out_valid",  128'(OUT_VALID),  128'(0));
    check("t6_rst_out_data",   128'(OUT_DATA),   128'(0));
    check("t6_rst_out_words",  128'(OUT_WORDS),  128'(0));
    check("t6_rst_fifo_ready", 128'(FIFO_READY), 128'(0));
    check("t6_rst_txn_ready",  128'(TXN_READY),  128'(1));
    src_q.delete();
    exp_q.delete();
    hold_prev = 0;
    txn_req = 0;
    @(negedge CLK);
    RST = 1'b0;
    start(4, 32'h300);
    finish(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
